// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: IF-fetch, MEM-access and byte-wide RAM signals of mem_ctrl.
// Signal suffixes are from the controller's point of view.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [31:0]       if_inst_o;
   logic              if_done_o;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [7:0]        mem_data_i;
   logic [7:0]        mem_data_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_we_o;
   logic [7:0]        ram_dout_o;
   logic [7:0]        ram_din_i;
   modport slave (
      input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_data_i, ram_din_i,
      output if_inst_o, if_done_o, mem_data_o, ram_addr_o, ram_we_o, ram_dout_o
   );
   modport master (
      output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_data_i, ram_din_i,
      input  if_inst_o, if_done_o, mem_data_o, ram_addr_o, ram_we_o, ram_dout_o
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM owner; MEM passes straight through, IF gets 4-byte LE fetches.
// Define MEM_CTRL_IBUF_EN to add a one-entry fetch buffer that answers repeat fetches.
module mem_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int RAM_LAT = 1
) (
   input logic      clk,
   input logic      rst_n,
   mem_ctrl_if.slave bus
);
   if (RAM_LAT != 1) begin : g_lat_chk
      $error("mem_ctrl: only RAM_LAT=1 is supported");
   end
   typedef enum logic [1:0] {IDLE, FETCH, MEMWAIT} state_t;
   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [23:0]       b_q, b_d;
   logic [31:0]       inst_q, inst_d;
   logic              done_q, done_d;
   logic              ib_hit;
   logic [31:0]       ib_word;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fetch_addr_q <= '0;
         b_q          <= '0;
         inst_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fetch_addr_q <= fetch_addr_d;
         b_q          <= b_d;
         inst_q       <= inst_d;
         done_q       <= done_d;
      end
   end
   // Bytes shift in from the top so b0 lands in [7:0] after the third capture.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fetch_addr_d = fetch_addr_q;
      b_d          = b_q;
      inst_d       = inst_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: if (!bus.mem_req_i && bus.if_req_i && !done_q) begin
            if (ib_hit) begin
               inst_d = ib_word;
               done_d = 1'b1;
            end else begin
               state_d      = FETCH;
               cnt_d        = '0;
               fetch_addr_d = bus.if_addr_i;
            end
         end
         FETCH: if (bus.mem_req_i) begin
            state_d = MEMWAIT;
            cnt_d   = '0;
         end else if (bus.if_addr_i != fetch_addr_q) begin
            cnt_d        = '0;
            fetch_addr_d = bus.if_addr_i;
         end else if (!bus.if_req_i) begin
            state_d = IDLE;
         end else if (cnt_q == 3'd4) begin
            inst_d  = {bus.ram_din_i, b_q};
            done_d  = 1'b1;
            state_d = IDLE;
         end else begin
            b_d   = (cnt_q != 3'd0) ? {bus.ram_din_i, b_q[23:8]} : b_q;
            cnt_d = cnt_q + 3'd1;
         end
         MEMWAIT: if (!bus.mem_req_i) begin
            state_d      = bus.if_req_i ? FETCH : IDLE;
            cnt_d        = '0;
            fetch_addr_d = bus.if_req_i ? bus.if_addr_i : fetch_addr_q;
         end
         default: state_d = IDLE;
      endcase
   end
   // RAM outputs are gated by rst_n so reset silences the port without a clock.
   always_comb begin
      bus.ram_addr_o = !rst_n ? '0 : bus.mem_req_i ? bus.mem_addr_i :
                       (state_q == FETCH && cnt_q < 3'd4) ? fetch_addr_q + ADDR_W'(cnt_q) : '0;
      bus.ram_we_o   = rst_n && bus.mem_req_i && bus.mem_we_i;
      bus.ram_dout_o = (rst_n && bus.mem_req_i) ? bus.mem_data_i : '0;
   end
   assign bus.if_inst_o  = inst_q;
   assign bus.if_done_o  = done_q;
   assign bus.mem_data_o = bus.ram_din_i;
`ifdef MEM_CTRL_IBUF_EN
   logic              ib_v_q;
   logic [ADDR_W-1:0] ib_a_q;
   logic [31:0]       ib_w_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ib_v_q <= 1'b0;
         ib_a_q <= '0;
         ib_w_q <= '0;
      end else begin
         ib_v_q <= !bus.ram_we_o && (done_d || ib_v_q);
         ib_a_q <= done_d ? bus.if_addr_i : ib_a_q;
         ib_w_q <= done_d ? inst_d : ib_w_q;
      end
   end
   assign ib_hit  = ib_v_q && bus.if_addr_i == ib_a_q;
   assign ib_word = ib_w_q;
`else
   assign ib_hit  = 1'b0;
   assign ib_word = '0;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a 1-cycle-latency byte RAM model.
// Builds with or without MEM_CTRL_IBUF_EN; only the repeat-fetch latency differs.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   vecs = 0;
   int   errs = 0;
   int   k;
   logic [7:0] ram [0:511] = '{default: 8'h00};
`ifdef MEM_CTRL_IBUF_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 6;
`endif
   logic [31:0] pa [12] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 32'h21, 32'h22, 32'h23,
                            32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
   logic [7:0]  pd [12] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                            8'h11, 8'h22, 8'h33, 8'h44};
   mem_ctrl_if #(.ADDR_W(32)) bus ();
   mem_ctrl #(.ADDR_W(32), .RAM_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.ram_we_o) ram[bus.ram_addr_o[8:0]] <= bus.ram_dout_o;
      bus.ram_din_i <= ram[bus.ram_addr_o[8:0]];
   end
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic mem_wr(input logic [31:0] a, input logic [7:0] d);
      bus.mem_req_i  = 1'b1;
      bus.mem_we_i   = 1'b1;
      bus.mem_addr_i = a;
      bus.mem_data_i = d;
      nxt();
   endtask
   task automatic wait_done(output int n);
      n = 0;
      do begin
         nxt();
         n++;
      end while (!bus.if_done_o && n < 20);
   endtask
   task automatic run_fetch(input logic [31:0] a, input logic [31:0] w, input int lat, input string tag);
      int n = 0;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = a;
      do begin
         nxt();
         n++;
         if (lat == 6 && n <= 4) chk({tag, "_addr"}, bus.ram_addr_o, a + 32'(n - 1));
      end while (!bus.if_done_o && n < 20);
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_word"}, bus.if_inst_o, w);
      bus.if_req_i = 1'b0;
      nxt();
      chk({tag, "_pulse"}, bus.if_done_o, 32'd0);
      chk({tag, "_hold"}, bus.if_inst_o, w);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.if_req_i   = 1'b0;
      bus.if_addr_i  = '0;
      bus.mem_req_i  = 1'b1;
      bus.mem_we_i   = 1'b1;
      bus.mem_addr_i = 32'h55;
      bus.mem_data_i = 8'hCC;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_we", bus.ram_we_o, 32'd0);
      chk("rst_addr", bus.ram_addr_o, 32'd0);
      chk("rst_dout", bus.ram_dout_o, 32'd0);
      chk("rst_done", bus.if_done_o, 32'd0);
      chk("rst_inst", bus.if_inst_o, 32'd0);
      nxt();
      nxt();
      chk("rst_nowrite", ram[9'h55], 32'd0);
      bus.mem_req_i = 1'b0;
      bus.mem_we_i  = 1'b0;
      rst_n = 1'b1;
      nxt();
      for (int i = 0; i < 12; i++) mem_wr(pa[i], pd[i]);
      bus.mem_req_i = 1'b0;
      bus.mem_we_i  = 1'b0;
      nxt();
      run_fetch(32'h10, 32'h0050_0093, 6, "basic");
      bus.mem_req_i  = 1'b1;
      bus.mem_addr_i = 32'h10;
      bus.if_req_i   = 1'b1;
      bus.if_addr_i  = 32'h20;
      #1;
      chk("sim_addr", bus.ram_addr_o, 32'h10);
      chk("sim_we", bus.ram_we_o, 32'd0);
      nxt();
      chk("sim_hold", bus.ram_addr_o, 32'h10);
      chk("sim_rdata", bus.mem_data_o, 32'h93);
      bus.mem_req_i = 1'b0;
      #1;
      chk("sim_nofetch", bus.ram_addr_o, 32'd0);
      nxt();
      chk("sim_start", bus.ram_addr_o, 32'h20);
      wait_done(k);
      chk("sim_lat", 32'(k), 32'd5);
      chk("sim_word", bus.if_inst_o, 32'h0010_0513);
      bus.if_req_i = 1'b0;
      nxt();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h10;
      nxt();
      nxt();
      nxt();
      chk("pre_cnt2", bus.ram_addr_o, 32'h12);
      bus.mem_req_i  = 1'b1;
      bus.mem_we_i   = 1'b1;
      bus.mem_addr_i = 32'h100;
      bus.mem_data_i = 8'hAB;
      #1;
      chk("pre_addr", bus.ram_addr_o, 32'h100);
      chk("pre_we", bus.ram_we_o, 32'd1);
      nxt();
      chk("pre_nodone1", bus.if_done_o, 32'd0);
      nxt();
      chk("pre_nodone2", bus.if_done_o, 32'd0);
      bus.mem_req_i = 1'b0;
      bus.mem_we_i  = 1'b0;
      #1;
      chk("pre_wait", bus.ram_addr_o, 32'd0);
      nxt();
      chk("pre_restart", bus.ram_addr_o, 32'h10);
      wait_done(k);
      chk("pre_lat", 32'(k), 32'd5);
      chk("pre_word", bus.if_inst_o, 32'h0050_0093);
      chk("pre_ram", ram[9'h100], 32'hAB);
      bus.if_req_i = 1'b0;
      nxt();
      run_fetch(32'hFFFF_FFFE, 32'h4433_2211, 6, "wrap");
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h10;
      nxt();
      nxt();
      nxt();
      nxt();
      chk("rdr_cnt3", bus.ram_addr_o, 32'h13);
      bus.if_addr_i = 32'h20;
      nxt();
      chk("rdr_restart", bus.ram_addr_o, 32'h20);
      wait_done(k);
      chk("rdr_lat", 32'(k), 32'd5);
      chk("rdr_word", bus.if_inst_o, 32'h0010_0513);
      bus.if_req_i = 1'b0;
      nxt();
      run_fetch(32'h10, 32'h0050_0093, 6, "refill");
      run_fetch(32'h10, 32'h0050_0093, HIT_LAT, "repeat");
      mem_wr(32'h11, 8'hFF);
      bus.mem_req_i = 1'b0;
      bus.mem_we_i  = 1'b0;
      run_fetch(32'h10, 32'h0050_FF93, 6, "afterwr");
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h20;
      nxt();
      nxt();
      nxt();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_done", bus.if_done_o, 32'd0);
      chk("arst_addr", bus.ram_addr_o, 32'd0);
      chk("arst_inst", bus.if_inst_o, 32'd0);
      bus.if_req_i = 1'b0;
      nxt();
      rst_n = 1'b1;
      nxt();
      bus.mem_req_i  = 1'b1;
      bus.mem_we_i   = 1'b1;
      bus.mem_addr_i = 32'h150;
      bus.mem_data_i = 8'h77;
      #1;
      chk("arstw_we_on", bus.ram_we_o, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arstw_we_off", bus.ram_we_o, 32'd0);
      chk("arstw_addr", bus.ram_addr_o, 32'd0);
      nxt();
      nxt();
      chk("arstw_nowrite", ram[9'h150], 32'd0);
      bus.mem_req_i = 1'b0;
      bus.mem_we_i  = 1'b0;
      rst_n = 1'b1;
      nxt();
      chk("arstw_done", bus.if_done_o, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
